// File: rtl/flow_path_scheduler_pkg.sv
// rtl/flow_path_scheduler_pkg.sv - shared types, merge codes and tap decode for the flow path scheduler
package flow_sched_pkg;

  typedef enum logic [2:0] {IDLE, ROUTE, LOAD, PROC, DRAIN, DONE} state_e;
  typedef enum logic {SIDE_A, SIDE_B} side_e;

  localparam logic [1:0] MERGE_OFF = 2'b00;
  localparam logic [1:0] MERGE_A   = 2'b01;
  localparam logic [1:0] MERGE_B   = 2'b10;
  localparam int         TGT_W     = 5;

  // Each junction4 switch carries two taps; the low bit only picks the side.
  function automatic logic [TGT_W-2:0] tap_to_switch(input logic [TGT_W-1:0] tgt);
    return tgt[TGT_W-1:1];
  endfunction

endpackage

// File: rtl/flow_path_scheduler_if.sv
// rtl/flow_path_scheduler_if.sv - job request/grant/complete handshake for both source chains
interface flow_path_scheduler_if #(
  parameter int TW = 16
);
  logic          req_a;
  logic          req_b;
  logic [4:0]    tgt_a;
  logic [4:0]    tgt_b;
  logic [TW-1:0] dwell_a;
  logic [TW-1:0] dwell_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          done_a;
  logic          done_b;
  logic          err;

  modport master (
    output req_a, req_b, tgt_a, tgt_b, dwell_a, dwell_b,
    input  gnt_a, gnt_b, done_a, done_b, err
  );

  modport slave (
    input  req_a, req_b, tgt_a, tgt_b, dwell_a, dwell_b,
    output gnt_a, gnt_b, done_a, done_b, err
  );
endinterface

// File: rtl/flow_path_scheduler_dwell_timer.sv
// rtl/flow_path_scheduler_dwell_timer.sv - loadable down-counter; expire_o marks the last cycle of a phase
module flow_dwell_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] value_i,
  output logic          expire_o
);
  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == TW'(1));
endmodule

// File: rtl/flow_path_scheduler.sv
// rtl/flow_path_scheduler.sv - round-robin scheduler for two flow-switch chains and the shared junction3 tail
// FLOW_SCHED_ABORT_EN adds abort_i, which cuts ROUTE/LOAD/PROC short into a full DRAIN ending in err.
module flow_path_scheduler
  import flow_sched_pkg::*;
#(
  parameter int N_SW       = 9,
  parameter int TW         = 16,
  parameter int SETTLE_CYC = 2,
  parameter int FILL_CYC   = 4,
  parameter int DRAIN_CYC  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  flow_path_scheduler_if.slave  job,
`ifdef FLOW_SCHED_ABORT_EN
  input  logic                  abort_i,
`endif
  output logic [N_SW-1:0]       valve_a_o,
  output logic [N_SW-1:0]       valve_b_o,
  output logic [2*N_SW-1:0]     tap_a_o,
  output logic [2*N_SW-1:0]     tap_b_o,
  output logic [1:0]            merge_sel_o,
  output logic                  pump_en_o,
  output logic                  tail_en_o,
  output logic                  busy_o
);
  state_e        state_q, state_d;
  side_e         side_q, side_d, last_q, last_d;
  logic [4:0]    tgt_q, tgt_d;
  logic [TW-1:0] dwell_q, dwell_d;
  logic          inv_q, inv_d, abt_q, abt_d, gnt_q, gnt_d;
  logic          tmr_load, tmr_exp, abort;
  logic [TW-1:0] tmr_val;

`ifdef FLOW_SCHED_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  flow_dwell_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmr_load),
    .value_i  (tmr_val),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    last_d   = last_q;
    tgt_d    = tgt_q;
    dwell_d  = dwell_q;
    inv_d    = inv_q;
    abt_d    = abt_q;
    gnt_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TW'(SETTLE_CYC);
    if (abort && !inv_q && (state_q inside {ROUTE, LOAD, PROC})) begin
      state_d  = DRAIN;
      abt_d    = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = TW'(DRAIN_CYC);
    end else begin
      case (state_q)
        IDLE: if (job.req_a || job.req_b) begin
          // Contention goes to the side that was not granted last.
          side_d   = (job.req_a && (!job.req_b || last_q == SIDE_B)) ? SIDE_A : SIDE_B;
          last_d   = side_d;
          tgt_d    = (side_d == SIDE_A) ? job.tgt_a : job.tgt_b;
          dwell_d  = (side_d == SIDE_A) ? job.dwell_a : job.dwell_b;
          inv_d    = (int'(tgt_d) >= 2 * N_SW);
          abt_d    = 1'b0;
          gnt_d    = 1'b1;
          tmr_load = 1'b1;
          state_d  = ROUTE;
        end
        ROUTE: begin
          if (inv_q) begin
            state_d = DONE;
          end else if (tmr_exp) begin
            state_d  = LOAD;
            tmr_load = 1'b1;
            tmr_val  = TW'(FILL_CYC);
          end
        end
        LOAD: if (tmr_exp) begin
          state_d  = (dwell_q != '0) ? PROC : DRAIN;
          tmr_load = 1'b1;
          tmr_val  = (dwell_q != '0) ? dwell_q : TW'(DRAIN_CYC);
        end
        PROC: if (tmr_exp) begin
          state_d  = DRAIN;
          tmr_load = 1'b1;
          tmr_val  = TW'(DRAIN_CYC);
        end
        DRAIN: if (tmr_exp) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      side_q  <= SIDE_A;
      last_q  <= SIDE_B;
      tgt_q   <= '0;
      dwell_q <= '0;
      inv_q   <= 1'b0;
      abt_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      last_q  <= last_d;
      tgt_q   <= tgt_d;
      dwell_q <= dwell_d;
      inv_q   <= inv_d;
      abt_q   <= abt_d;
      gnt_q   <= gnt_d;
    end
  end

  logic [N_SW-1:0]   lo_mask, hi_mask;
  logic [2*N_SW-1:0] tap_vec;
  logic              feed, drain;

  always_comb begin
    valve_a_o   = '0;
    valve_b_o   = '0;
    tap_a_o     = '0;
    tap_b_o     = '0;
    merge_sel_o = MERGE_OFF;
    lo_mask     = '0;
    hi_mask     = '0;
    tap_vec     = '0;
    for (int i = 0; i < N_SW; i++) begin
      lo_mask[i] = (i <= int'(tap_to_switch(tgt_q)));
      hi_mask[i] = (i >= int'(tap_to_switch(tgt_q)));
    end
    for (int i = 0; i < 2 * N_SW; i++) begin
      tap_vec[i] = (i == int'(tgt_q));
    end
    // Filling opens the chain up to the tap; draining opens it from the tap onward to junction3.
    feed  = !inv_q && (state_q inside {ROUTE, LOAD, PROC});
    drain = (state_q == DRAIN);
    if (feed || drain) begin
      if (side_q == SIDE_A) begin
        valve_a_o = feed ? lo_mask : hi_mask;
        tap_a_o   = tap_vec;
      end else begin
        valve_b_o = feed ? lo_mask : hi_mask;
        tap_b_o   = tap_vec;
      end
    end
    if (drain) merge_sel_o = (side_q == SIDE_A) ? MERGE_A : MERGE_B;
    pump_en_o = (state_q == LOAD) || drain;
    tail_en_o = drain;
    busy_o    = (state_q != IDLE);
  end

  assign job.gnt_a  = gnt_q && (side_q == SIDE_A);
  assign job.gnt_b  = gnt_q && (side_q == SIDE_B);
  assign job.done_a = (state_q == DONE) && (side_q == SIDE_A);
  assign job.done_b = (state_q == DONE) && (side_q == SIDE_B);
  assign job.err    = (state_q == DONE) && (inv_q || abt_q);
endmodule

// File: tb/tb_flow_path_scheduler.sv
// tb/tb_flow_path_scheduler.sv - directed scenarios plus randomized jobs against a phase-offset reference model
module tb_flow_path_scheduler;
  localparam int N_SW = 9;
  localparam int TW   = 16;
  localparam int S    = 2;
  localparam int F    = 4;
  localparam int R    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flow_path_scheduler_if #(.TW(TW)) job ();
  logic [N_SW-1:0]   valve_a, valve_b;
  logic [2*N_SW-1:0] tap_a, tap_b;
  logic [1:0]        merge_sel;
  logic              pump_en, tail_en, busy;
`ifdef FLOW_SCHED_ABORT_EN
  logic              abort;
`endif

  flow_path_scheduler #(
    .N_SW(N_SW), .TW(TW), .SETTLE_CYC(S), .FILL_CYC(F), .DRAIN_CYC(R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .job         (job),
`ifdef FLOW_SCHED_ABORT_EN
    .abort_i     (abort),
`endif
    .valve_a_o   (valve_a),
    .valve_b_o   (valve_b),
    .tap_a_o     (tap_a),
    .tap_b_o     (tap_b),
    .merge_sel_o (merge_sel),
    .pump_en_o   (pump_en),
    .tail_en_o   (tail_en),
    .busy_o      (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_viol = 0;
  int n_mon = 0;

  always @(negedge clk) begin
    n_mon <= n_mon + 1;
    if ((valve_a != '0 && valve_b != '0) || merge_sel == 2'b11) n_viol <= n_viol + 1;
  end

  function automatic logic [63:0] obs();
    return {job.gnt_a, job.gnt_b, job.done_a, job.done_b, job.err,
            valve_a, valve_b, tap_a, tap_b, merge_sel, pump_en, tail_en, busy};
  endfunction

  // Expected outputs t cycles after a grant, derived from the phase lengths alone.
  function automatic logic [63:0] model(bit act, int t, bit sb, int tgt, int dw);
    logic [N_SW-1:0]   v  = '0;
    logic [2*N_SW-1:0] tp = '0;
    logic [1:0]        m  = 2'b00;
    bit g = 0, d = 0, e = 0, p = 0, tl = 0, b = 0;
    bit inv = (tgt >= 2 * N_SW);
    int k   = tgt / 2;
    int len = inv ? 1 : S + F + dw + R;
    if (act) begin
      b = 1;
      g = (t == 0);
      if (t == len) begin
        d = 1;
        e = inv;
      end else if (!inv) begin
        tp[tgt] = 1'b1;
        if (t < S + F + dw) begin
          for (int i = 0; i <= k; i++) v[i] = 1'b1;
          p = (t >= S && t < S + F);
        end else begin
          for (int i = k; i < N_SW; i++) v[i] = 1'b1;
          m  = sb ? 2'b10 : 2'b01;
          p  = 1;
          tl = 1;
        end
      end
    end
    return {g & !sb, g & sb, d & !sb, d & sb, e,
            sb ? 9'b0 : v, sb ? v : 9'b0, sb ? 18'b0 : tp, sb ? tp : 18'b0, m, p, tl, b};
  endfunction

  task automatic idle_inputs();
    job.req_a = 0; job.req_b = 0;
    job.tgt_a = '0; job.tgt_b = '0;
    job.dwell_a = '0; job.dwell_b = '0;
`ifdef FLOW_SCHED_ABORT_EN
    abort = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    #1;
    n_cmp++;
    if (obs() !== 64'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", obs(), 64'h0);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== 64'h0) begin
      n_err++; $display("FAIL idle_after_reset: got %h want %h", obs(), 64'h0);
    end
  endtask

  task automatic test_single_job();
    logic [8:0] va; logic [17:0] ta; logic [1:0] m; logic p, tl, b;
    logic [63:0] exp;
    do_reset();
    job.req_a = 1; job.tgt_a = 5'd5; job.dwell_a = 16'd10;
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      job.req_a = 0;
      va = (c <= 15) ? 9'b000000111 : (c <= 18) ? 9'b111111100 : 9'b0;
      ta = (c <= 18) ? 18'h00020 : 18'h0;
      m  = (c >= 16 && c <= 18) ? 2'b01 : 2'b00;
      p  = (c >= 2 && c <= 5) || (c >= 16 && c <= 18);
      tl = (c >= 16 && c <= 18);
      b  = (c <= 19);
      exp = {c == 0, 1'b0, c == 19, 1'b0, 1'b0, va, 9'b0, ta, 18'b0, m, p, tl, b};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++; $display("FAIL single_job c%0d: got %h want %h", c, obs(), exp);
      end
    end
  endtask

  task automatic test_invalid();
    logic [63:0] exp [3];
    exp[0] = {5'b01000, 59'h1};
    exp[1] = {5'b00011, 59'h1};
    exp[2] = 64'h0;
    do_reset();
    job.req_b = 1; job.tgt_b = 5'd18; job.dwell_b = 16'd7;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      job.req_b = 0;
      n_cmp++;
      if (obs() !== exp[c]) begin
        n_err++; $display("FAIL invalid_tgt c%0d: got %h want %h", c, obs(), exp[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    int gc [$]; bit gs [$];
    do_reset();
    job.req_a = 1; job.req_b = 1; job.tgt_a = 5'd3; job.tgt_b = 5'd8;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (job.gnt_a || job.gnt_b) begin
        gc.push_back(c); gs.push_back(job.gnt_b);
      end
    end
    idle_inputs();
    n_cmp++;
    if (gc.size() < 3) begin
      n_err++; $display("FAIL rr_grant_count: got %0d want 3", gc.size());
    end else begin
      n_cmp++;
      if (gc[0] != 0 || gc[1] != 11 || gc[2] != 22) begin
        n_err++; $display("FAIL rr_grant_cycles: got %0d,%0d,%0d want 0,11,22", gc[0], gc[1], gc[2]);
      end
      n_cmp++;
      if (gs[0] != 0 || gs[1] != 1 || gs[2] != 0) begin
        n_err++; $display("FAIL rr_grant_order: got %0d%0d%0d want 010 (0=A)", gs[0], gs[1], gs[2]);
      end
    end
  endtask

  task automatic test_reset_mid_proc();
    do_reset();
    job.req_a = 1; job.tgt_a = 5'd2; job.dwell_a = 16'd20;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      job.req_a = 0;
    end
    n_cmp++;
    if (valve_a !== 9'b000000011 || pump_en !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL proc_before_reset: got valve=%b pump=%b busy=%b want 000000011 0 1", valve_a, pump_en, busy);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if (obs() !== 64'h0) begin
      n_err++; $display("FAIL reset_immediate: got %h want %h", obs(), 64'h0);
    end
    @(negedge clk);
    n_cmp++;
    if (obs() !== 64'h0) begin
      n_err++; $display("FAIL reset_no_done: got %h want %h", obs(), 64'h0);
    end
    rst = 0;
    job.req_a = 1; job.req_b = 1; job.tgt_a = 5'd1; job.tgt_b = 5'd1;
    @(negedge clk);
    idle_inputs();
    n_cmp++;
    if (job.gnt_a !== 1'b1 || job.gnt_b !== 1'b0) begin
      n_err++; $display("FAIL rr_after_reset: got gnt_a=%b gnt_b=%b want 1 0", job.gnt_a, job.gnt_b);
    end
  endtask

`ifdef FLOW_SCHED_ABORT_EN
  task automatic test_abort();
    do_reset();
    job.req_a = 1; job.tgt_a = 5'd4; job.dwell_a = 16'd5;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      job.req_a = 0;
      abort = (c == 3);
      n_cmp++;
      if (tail_en !== (c >= 4 && c <= 6) || job.done_a !== (c == 7) || job.err !== (c == 7)) begin
        n_err++; $display("FAIL abort_load c%0d: got tail=%b done=%b err=%b", c, tail_en, job.done_a, job.err);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit act = 0, sb = 0, last_b = 1;
    int t = 0, tgt = 0, dw = 0, len = 0;
    logic [63:0] exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      exp = model(act, t, sb, tgt, dw);
      n_cmp++;
      if (obs() !== exp) begin
        n_err++; $display("FAIL random n%0d t%0d: got %h want %h", n, t, obs(), exp);
      end
      job.req_a = ($urandom_range(0, 3) == 0);
      job.req_b = ($urandom_range(0, 3) == 0);
      job.tgt_a = 5'($urandom_range(0, 20));
      job.tgt_b = 5'($urandom_range(0, 20));
      job.dwell_a = 16'($urandom_range(0, 5));
      job.dwell_b = 16'($urandom_range(0, 5));
      if (!act) begin
        if (job.req_a || job.req_b) begin
          sb     = !(job.req_a && (!job.req_b || last_b));
          last_b = sb;
          tgt    = sb ? int'(job.tgt_b) : int'(job.tgt_a);
          dw     = sb ? int'(job.dwell_b) : int'(job.dwell_a);
          len    = (tgt >= 2 * N_SW) ? 1 : S + F + dw + R;
          act    = 1;
          t      = 0;
        end
      end else if (t == len) begin
        act = 0;
      end else begin
        t++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_exclusion();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (n_viol != 0 || n_mon < 100) begin
      n_err++; $display("FAIL chain_exclusion: got %0d violations over %0d cycles want 0", n_viol, n_mon);
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_invalid();
    test_round_robin();
    test_reset_mid_proc();
`ifdef FLOW_SCHED_ABORT_EN
    test_abort();
`endif
    test_random();
    test_exclusion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
